// File: rtl/game_stat_pkg.sv
// Shared types and constants for the snake game stat tracker.
// State enum, BCD digit constants and the prescaler divide helper.
package game_stat_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_PAUSED,
        S_OVER
    } state_t;

    localparam int BCD_W = 4;
    localparam logic [BCD_W-1:0] BCD_NINE = 4'd9;

    // Clock cycles per time tick.
    function automatic int tick_div(input int clk_hz, input int tick_hz);
        return clk_hz / tick_hz;
    endfunction

endpackage

// File: rtl/game_stat_tracker_if.sv
// Control inputs and BCD stat outputs of the stat tracker.
// master drives game events, slave is the tracker itself.
interface game_stat_tracker_if
    import game_stat_pkg::*;
#(
    parameter int SCORE_DIGITS = 4,
    parameter int TIME_DIGITS  = 4
);
    logic                            start;
    logic                            pause;
    logic                            apple_hit;
    logic                            death;
    logic [BCD_W*SCORE_DIGITS-1:0]   score_bcd;
    logic [BCD_W*TIME_DIGITS-1:0]    time_bcd;
    logic [BCD_W*SCORE_DIGITS-1:0]   hiscore_bcd;
    logic                            apple_load;
    logic                            running;
    logic                            game_over;

    modport master (
        output start, pause, apple_hit, death,
        input  score_bcd, time_bcd, hiscore_bcd,
        input  apple_load, running, game_over
    );

    modport slave (
        input  start, pause, apple_hit, death,
        output score_bcd, time_bcd, hiscore_bcd,
        output apple_load, running, game_over
    );
endinterface

// File: rtl/game_stat_tracker_bcd_counter.sv
// Saturating packed-BCD up-counter, digit 0 is least significant.
// Stops at all nines; clr has priority over inc.
module bcd_counter
    import game_stat_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clr,
    input  logic                    inc,
    output logic [BCD_W*DIGITS-1:0] q,
    output logic                    at_max
);
    logic [BCD_W*DIGITS-1:0] cnt_q;
    logic [BCD_W*DIGITS-1:0] cnt_d;
    logic                    carry;
    logic [BCD_W-1:0]        dig;

    // Ripple a +1 through the digits; a nine wraps to zero and carries.
    always_comb begin
        cnt_d  = cnt_q;
        carry  = 1'b1;
        at_max = 1'b1;
        dig    = '0;
        for (int i = 0; i < DIGITS; i++) begin
            dig = cnt_q[i*BCD_W +: BCD_W];
            if (dig != BCD_NINE) begin
                at_max = 1'b0;
            end
            if (carry) begin
                if (dig == BCD_NINE) begin
                    cnt_d[i*BCD_W +: BCD_W] = '0;
                end else begin
                    cnt_d[i*BCD_W +: BCD_W] = dig + 4'd1;
                    carry = 1'b0;
                end
            end
        end
    end

    // Count register, held once every digit reads nine.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (inc && !at_max) begin
            cnt_q <= cnt_d;
        end
    end

    assign q = cnt_q;
endmodule

// File: rtl/game_stat_tracker.sv
// Snake game score / elapsed-time tracker with packed BCD outputs.
// Define GAME_STAT_HISCORE_EN to keep a best-score register.
module game_stat_tracker
    import game_stat_pkg::*;
#(
    parameter int CLK_HZ       = 100000000,
    parameter int TICK_HZ      = 1,
    parameter int SCORE_DIGITS = 4,
    parameter int TIME_DIGITS  = 4
) (
    input logic                clk,
    input logic                rst_n,
    game_stat_tracker_if.slave bus
);
    localparam int TICK_DIV = tick_div(CLK_HZ, TICK_HZ);
    localparam int PW       = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

    state_t                        state_q, state_d;
    logic                          apple_q;
    logic [PW-1:0]                 pre_q, pre_d;
    logic                          load_q, load_d;
    logic                          running_q;
    logic                          over_q;
    logic                          clr;
    logic                          score_inc;
    logic                          time_inc;
    logic                          score_max;
    logic                          time_max;
    logic                          apple_edge;
    logic [BCD_W*SCORE_DIGITS-1:0] score_q;
    logic [BCD_W*TIME_DIGITS-1:0]  time_q;

    assign apple_edge = bus.apple_hit & ~apple_q;

    // Game FSM next state, clears, apple requests and prescaler.
    always_comb begin
        state_d   = state_q;
        pre_d     = pre_q;
        load_d    = 1'b0;
        clr       = 1'b0;
        score_inc = 1'b0;
        time_inc  = 1'b0;
        unique case (state_q)
            S_IDLE, S_OVER: begin
                if (bus.start) begin
                    state_d = S_RUN;
                    clr     = 1'b1;
                    load_d  = 1'b1;
                    pre_d   = '0;
                end
            end
            S_RUN: begin
                if (bus.death) begin
                    state_d = S_OVER;
                end else if (bus.pause) begin
                    state_d = S_PAUSED;
                end else begin
                    if (apple_edge) begin
                        score_inc = ~score_max;
                        load_d    = 1'b1;
                    end
                    if (pre_q == PRE_LAST) begin
                        pre_d    = '0;
                        time_inc = ~time_max;
                    end else begin
                        pre_d = pre_q + 1'b1;
                    end
                end
            end
            S_PAUSED: begin
                if (!bus.pause) begin
                    state_d = S_RUN;
                end
            end
        endcase
    end

    // State, apple history and registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            apple_q   <= 1'b0;
            pre_q     <= '0;
            load_q    <= 1'b0;
            running_q <= 1'b0;
            over_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            apple_q   <= bus.apple_hit;
            pre_q     <= pre_d;
            load_q    <= load_d;
            running_q <= (state_d == S_RUN);
            over_q    <= (state_d == S_OVER);
        end
    end

    bcd_counter #(.DIGITS(SCORE_DIGITS)) u_score (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (clr),
        .inc    (score_inc),
        .q      (score_q),
        .at_max (score_max)
    );

    bcd_counter #(.DIGITS(TIME_DIGITS)) u_time (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (clr),
        .inc    (time_inc),
        .q      (time_q),
        .at_max (time_max)
    );

`ifdef GAME_STAT_HISCORE_EN
    logic [BCD_W*SCORE_DIGITS-1:0] hi_q;
    logic                          enter_over;

    assign enter_over = (state_q == S_RUN) && (state_d == S_OVER);

    // Packed BCD orders like unsigned binary, so > compares from the MSD.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_q <= '0;
        end else if (enter_over && (score_q > hi_q)) begin
            hi_q <= score_q;
        end
    end

    assign bus.hiscore_bcd = hi_q;
`else
    assign bus.hiscore_bcd = '0;
`endif

    assign bus.score_bcd  = score_q;
    assign bus.time_bcd   = time_q;
    assign bus.apple_load = load_q;
    assign bus.running    = running_q;
    assign bus.game_over  = over_q;
endmodule

// File: doc/game_stat_tracker.md
# game_stat_tracker

Synchronous score/elapsed-time tracker for the snake game, replacing the multi-edge stat logic in the game top. It runs a small game-state machine, counts apples once per collision edge, counts seconds from a parametrised prescaler, and issues apple-respawn pulses to the LFSR generators. It presents packed BCD to the 7-segment driver (`arr7seg_top`), with no binary-to-decimal step downstream.

## Interface
- `CLK_HZ`, 100000000, input clock frequency.
- `TICK_HZ`, 1, time-counter rate; `TICK_DIV = CLK_HZ/TICK_HZ` (integer, ≥2).
- `SCORE_DIGITS`, 4, BCD digits of score (1–8).
- `TIME_DIGITS`, 4, BCD digits of elapsed seconds (1–8).
- `clk` in 1: system clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `start` in 1: level; starts or restarts a game.
- `pause` in 1: level; freezes time while high.
- `apple_hit` in 1: level from graphics; may stay high many cycles.
- `death` in 1: level from graphics (snake collision).
- `score_bcd` out 4*SCORE_DIGITS: current score, digit 0 = LSD.
- `time_bcd` out 4*TIME_DIGITS: elapsed seconds, BCD.
- `hiscore_bcd` out 4*SCORE_DIGITS: best score since reset.
- `apple_load` out 1: one-cycle pulse requesting a new apple position.
- `running` out 1: high in RUN.
- `game_over` out 1: high in OVER.

## Operation
- States: IDLE, RUN, PAUSED, OVER. Reset → IDLE.
- IDLE: `start`=1 → RUN; clear score, time, prescaler; pulse `apple_load`.
- RUN: `death`=1 → OVER. Else `pause`=1 → PAUSED. Otherwise count.
- PAUSED: `pause`=0 → RUN; `death` ignored; `apple_hit` edge ignored; the registered copy of `apple_hit` still updates.
- OVER: score/time hold; `start`=1 → RUN with the same clears and `apple_load` pulse as from IDLE.
- Apple edge: `apple_hit`=1 while registered copy `apple_q`=0, in RUN. Score +1 and `apple_load` pulse. A level held high counts once.
- Death and apple edge on the same cycle: death wins; no increment; no `apple_load`.
- Score saturates at all-9s; further apples still pulse `apple_load`.
- Time: prescaler counts 0..TICK_DIV-1 in RUN only. At TICK_DIV-1 it wraps to 0 and time +1 (BCD, saturating at all-9s). PAUSED holds the prescaler value.
- Hiscore: on entry to OVER, if score > hiscore then hiscore ← score. Compare BCD digit-wise from MSD. Cleared only by reset.
- BCD arithmetic: per-digit carry; a digit at 9 wraps to 0 and carries.

## Timing
- Reset values: all BCD outputs 0, `apple_load`=0, `running`=0, `game_over`=0, `apple_q`=0, prescaler 0.
- All outputs are registered. Latency is one clock from the qualifying input sample to the visible change.
- `apple_load` is exactly one cycle wide and never back-to-back except on a distinct new edge.
- First time increment comes TICK_DIV RUN cycles after the start edge.
- Reset asserted mid-game returns to IDLE immediately; hiscore clears.
- `start` held high in RUN has no effect; restart requires passing through OVER.

## Configuration
- `GAME_STAT_HISCORE_EN` defined: hiscore register and compare present, as above.
- Undefined: no hiscore logic; `hiscore_bcd` is tied to 0.

## Structure
- `game_stat_pkg` holds:
  - state enum (IDLE/RUN/PAUSED/OVER);
  - BCD digit width constant (4);
  - BCD nine constant (4'd9);
  - `TICK_DIV` computation function.
- Sub-module `bcd_counter`:
  - parameter DIGITS;
  - ports clk, rst_n, clr, inc, `q`, `at_max`;
  - saturating.
- Instantiated twice: once for score, once for time.

## Test plan
Bench parameters: CLK_HZ=10, TICK_HZ=1 (TICK_DIV=10), SCORE_DIGITS=2, TIME_DIGITS=2.
- Start from IDLE; hold RUN 35 cycles. Expect `apple_load` one pulse on the start edge and `time_bcd`=0x03.
- `apple_hit` held high 20 cycles, then low, then high 1 cycle. Expect `score_bcd`=0x02 and exactly 3 `apple_load` pulses total (including start).
- Pause for 25 cycles mid-count. Expect `time_bcd` unchanged during pause; the next increment resumes where the prescaler stopped.
- `death` and `apple_hit` rise on the same cycle with score=0x07. Expect OVER, score 0x07. With `GAME_STAT_HISCORE_EN`, expect hiscore 0x07.
- Drive 101 apple edges. Expect `score_bcd` saturates at 0x99; `apple_load` still pulses each time.
- Drop `rst_n` in RUN. Expect all outputs 0 asynchronously and state IDLE; then `start` gives a clean game.
